// File: rtl/wb_writeback_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_writeback_queue_if
// Desc     : MEM/WB payload, register-file write port and forwarding lookup
//            bundle for the write-back queue.
// Revision : 1.0
// ============================================================================
interface wb_writeback_queue_if #(
  parameter int BITS_SIZE = 32,
  parameter int BITS_REGS = 5,
  parameter int DEPTH     = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                 i_valid;
  logic                 o_ready;
  logic                 i_reg_write;
  logic                 i_lui;
  logic [BITS_SIZE-1:0] i_extension;
  logic [BITS_SIZE-1:0] i_dato_mem;
  logic [1:0]           i_addr_low;
  logic [1:0]           i_size_filterL;
  logic                 i_zero_extend;
  logic                 i_mem_to_reg;
  logic [BITS_SIZE-1:0] i_alu;
  logic                 i_jal;
  logic [BITS_SIZE-1:0] i_pc8;
  logic [BITS_REGS-1:0] i_register_dst;
  logic                 i_rf_ready;
  logic                 o_rf_we;
  logic [BITS_REGS-1:0] o_rf_addr;
  logic [BITS_SIZE-1:0] o_rf_data;
  logic [BITS_REGS-1:0] i_lookup_addr;
  logic                 o_lookup_hit;
  logic [BITS_SIZE-1:0] o_lookup_data;
  logic [CNT_W-1:0]     o_count;
  logic                 o_full;
  logic                 o_empty;

  modport master (
    output i_valid, i_reg_write, i_lui, i_extension, i_dato_mem, i_addr_low,
           i_size_filterL, i_zero_extend, i_mem_to_reg, i_alu, i_jal, i_pc8,
           i_register_dst, i_rf_ready, i_lookup_addr,
    input  o_ready, o_rf_we, o_rf_addr, o_rf_data, o_lookup_hit, o_lookup_data,
           o_count, o_full, o_empty
  );

  modport slave (
    input  i_valid, i_reg_write, i_lui, i_extension, i_dato_mem, i_addr_low,
           i_size_filterL, i_zero_extend, i_mem_to_reg, i_alu, i_jal, i_pc8,
           i_register_dst, i_rf_ready, i_lookup_addr,
    output o_ready, o_rf_we, o_rf_addr, o_rf_data, o_lookup_hit, o_lookup_data,
           o_count, o_full, o_empty
  );
endinterface
`default_nettype wire

// File: rtl/wb_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_writeback_queue
// Desc     : MIPS write-back stage: load filter, result select and a DEPTH-entry
//            write queue draining into the register file, with forwarding lookup.
//            Optional macro WB_BYTE_OFFSET_EN: byte/half lane chosen by i_addr_low.
// Revision : 1.0
// ============================================================================
module wb_writeback_queue #(
  parameter int BITS_SIZE = 32,
  parameter int BITS_REGS = 5,
  parameter int DEPTH     = 4,
  parameter int LINK_REG  = 31
) (
  input logic                  i_clk,
  input logic                  i_reset,
  wb_writeback_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]     C_DEPTH = CNT_W'(DEPTH);
  localparam logic [BITS_REGS-1:0] C_LINK  = BITS_REGS'(LINK_REG);

  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_full;
  logic                 r_empty;
  logic [DEPTH-1:0]     r_valid;
  logic [BITS_REGS-1:0] r_addr [DEPTH];
  logic [BITS_SIZE-1:0] r_data [DEPTH];

  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [BITS_SIZE-1:0] w_load;
  logic [BITS_SIZE-1:0] w_result;
  logic [BITS_REGS-1:0] w_dst;
  logic                 w_push;
  logic                 w_pop;
  logic [CNT_W-1:0]     w_count_nxt;
  logic                 w_unused_ext;

  assign w_unused_ext = ^bus.i_extension[BITS_SIZE-1:16];

`ifdef WB_BYTE_OFFSET_EN
  always_comb begin
    w_byte = bus.i_dato_mem[7:0];
    case (bus.i_addr_low)
      2'd0:    w_byte = bus.i_dato_mem[7:0];
      2'd1:    w_byte = bus.i_dato_mem[15:8];
      2'd2:    w_byte = bus.i_dato_mem[23:16];
      default: w_byte = bus.i_dato_mem[31:24];
    endcase
    w_half = bus.i_addr_low[1] ? bus.i_dato_mem[31:16] : bus.i_dato_mem[15:0];
  end
`else
  logic w_unused_addr;
  assign w_unused_addr = ^bus.i_addr_low;
  assign w_byte = bus.i_dato_mem[7:0];
  assign w_half = bus.i_dato_mem[15:0];
`endif

  always_comb begin
    case (bus.i_size_filterL)
      2'b00:   w_load = bus.i_zero_extend ? BITS_SIZE'(w_byte)
                                          : {{(BITS_SIZE-8){w_byte[7]}}, w_byte};
      2'b01:   w_load = bus.i_zero_extend ? BITS_SIZE'(w_half)
                                          : {{(BITS_SIZE-16){w_half[15]}}, w_half};
      default: w_load = bus.i_dato_mem;
    endcase
  end

  always_comb begin
    if (bus.i_jal)             w_result = bus.i_pc8;
    else if (bus.i_lui)        w_result = BITS_SIZE'({bus.i_extension[15:0], 16'h0000});
    else if (bus.i_mem_to_reg) w_result = w_load;
    else                       w_result = bus.i_alu;
  end

  assign w_dst  = bus.i_jal ? C_LINK : bus.i_register_dst;
  // Payloads that write nothing (or only r0) are accepted and dropped here.
  assign w_push = bus.i_valid & bus.o_ready & (bus.i_reg_write | bus.i_jal) & (w_dst != '0);
  assign w_pop  = bus.o_rf_we;

  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_valid  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      // Push and pop never share a slot: pop needs non-empty, push needs non-full.
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_addr[r_wr_ptr]  <= w_dst;
        r_data[r_wr_ptr]  <= w_result;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == C_DEPTH);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Walk oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx               = '0;
    bus.o_lookup_hit  = 1'b0;
    bus.o_lookup_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_rd_ptr + PTR_W'(k);
      if (r_valid[idx] && (r_addr[idx] == bus.i_lookup_addr) && (bus.i_lookup_addr != '0)) begin
        bus.o_lookup_hit  = 1'b1;
        bus.o_lookup_data = r_data[idx];
      end
    end
  end

  assign bus.o_ready   = ~r_full & ~i_reset;
  assign bus.o_rf_we   = ~r_empty & bus.i_rf_ready;
  assign bus.o_rf_addr = r_empty ? '0 : r_addr[r_rd_ptr];
  assign bus.o_rf_data = r_empty ? '0 : r_data[r_rd_ptr];
  assign bus.o_count   = r_count;
  assign bus.o_full    = r_full;
  assign bus.o_empty   = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_wb_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_writeback_queue
// Desc     : Directed self-checking bench for wb_writeback_queue (DEPTH = 4).
// Revision : 1.0
// ============================================================================
module tb_wb_writeback_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  wb_writeback_queue_if #(.BITS_SIZE(32), .BITS_REGS(5), .DEPTH(4)) bus ();

  wb_writeback_queue #(
    .BITS_SIZE(32), .BITS_REGS(5), .DEPTH(4), .LINK_REG(31)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_fields();
    bus.i_valid        = 1'b0;
    bus.i_reg_write    = 1'b0;
    bus.i_lui          = 1'b0;
    bus.i_extension    = 32'h0;
    bus.i_dato_mem     = 32'h0;
    bus.i_addr_low     = 2'd0;
    bus.i_size_filterL = 2'd2;
    bus.i_zero_extend  = 1'b0;
    bus.i_mem_to_reg   = 1'b0;
    bus.i_alu          = 32'h0;
    bus.i_jal          = 1'b0;
    bus.i_pc8          = 32'h0;
    bus.i_register_dst = 5'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept();
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_fields();
    bus.i_rf_ready    = 1'b1;
    bus.i_lookup_addr = 5'd8;
    rst = 1'b1;
    step(); step();
    n_checks++; if (bus.o_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.o_ready); else n_pass++;
    n_checks++; if (bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 || bus.o_count !== 3'd0)
      $display("FAIL rst_status: empty %b full %b count %0d want 1 0 0", bus.o_empty, bus.o_full, bus.o_count); else n_pass++;
    n_checks++; if (bus.o_rf_we !== 1'b0 || bus.o_rf_addr !== 5'd0 || bus.o_rf_data !== 32'h0 || bus.o_lookup_hit !== 1'b0)
      $display("FAIL rst_outputs: we %b addr %0d data %h hit %b want 0 0 0 0", bus.o_rf_we, bus.o_rf_addr, bus.o_rf_data, bus.o_lookup_hit); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.o_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", bus.o_ready); else n_pass++;
  endtask

  task automatic test_alu_write();
    clear_fields();
    bus.i_rf_ready     = 1'b1;
    bus.i_reg_write    = 1'b1;
    bus.i_alu          = 32'h1234_5678;
    bus.i_register_dst = 5'd8;
    accept();
    n_checks++; if (bus.o_rf_we !== 1'b1 || bus.o_rf_addr !== 5'd8 || bus.o_rf_data !== 32'h1234_5678 || bus.o_count !== 3'd1)
      $display("FAIL alu_write: we %b addr %0d data %h count %0d want 1 8 12345678 1", bus.o_rf_we, bus.o_rf_addr, bus.o_rf_data, bus.o_count); else n_pass++;
    step();
    n_checks++; if (bus.o_count !== 3'd0 || bus.o_empty !== 1'b1 || bus.o_rf_we !== 1'b0)
      $display("FAIL alu_drain: count %0d empty %b we %b want 0 1 0", bus.o_count, bus.o_empty, bus.o_rf_we); else n_pass++;
  endtask

  task automatic test_load_filter();
    logic [31:0] exp_off;
    clear_fields();
    bus.i_rf_ready     = 1'b1;
    bus.i_reg_write    = 1'b1;
    bus.i_mem_to_reg   = 1'b1;
    bus.i_alu          = 32'hDEAD_BEEF;
    bus.i_dato_mem     = 32'h8899_AABB;
    bus.i_register_dst = 5'd4;

    bus.i_size_filterL = 2'b00; bus.i_zero_extend = 1'b0;
    accept();
    n_checks++; if (bus.o_rf_data !== 32'hFFFF_FFBB || bus.o_rf_addr !== 5'd4)
      $display("FAIL byte_sext: data %h addr %0d want ffffffbb 4", bus.o_rf_data, bus.o_rf_addr); else n_pass++;
    step();

    bus.i_zero_extend = 1'b1;
    accept();
    n_checks++; if (bus.o_rf_data !== 32'h0000_00BB) $display("FAIL byte_zext: data %h want 000000bb", bus.o_rf_data); else n_pass++;
    step();

    bus.i_zero_extend = 1'b0; bus.i_addr_low = 2'd2;
`ifdef WB_BYTE_OFFSET_EN
    exp_off = 32'hFFFF_FF99;
`else
    exp_off = 32'hFFFF_FFBB;
`endif
    accept();
    n_checks++; if (bus.o_rf_data !== exp_off) $display("FAIL byte_lane2: data %h want %h", bus.o_rf_data, exp_off); else n_pass++;
    step();

    bus.i_addr_low = 2'd0; bus.i_size_filterL = 2'b01;
    accept();
    n_checks++; if (bus.o_rf_data !== 32'hFFFF_AABB) $display("FAIL half_sext: data %h want ffffaabb", bus.o_rf_data); else n_pass++;
    step();

    bus.i_size_filterL = 2'b10;
    accept();
    n_checks++; if (bus.o_rf_data !== 32'h8899_AABB) $display("FAIL word: data %h want 8899aabb", bus.o_rf_data); else n_pass++;
    step();
  endtask

  task automatic test_jal_lui();
    clear_fields();
    bus.i_rf_ready     = 1'b1;
    bus.i_jal          = 1'b1;
    bus.i_lui          = 1'b1;
    bus.i_extension    = 32'h0000_1111;
    bus.i_pc8          = 32'h0000_0040;
    bus.i_register_dst = 5'd3;
    accept();
    n_checks++; if (bus.o_rf_addr !== 5'd31 || bus.o_rf_data !== 32'h40 || bus.o_rf_we !== 1'b1)
      $display("FAIL jal: addr %0d data %h we %b want 31 40 1", bus.o_rf_addr, bus.o_rf_data, bus.o_rf_we); else n_pass++;
    step();

    clear_fields();
    bus.i_reg_write    = 1'b1;
    bus.i_lui          = 1'b1;
    bus.i_extension    = 32'hFFFF_ABCD;
    bus.i_alu          = 32'h5555_5555;
    bus.i_register_dst = 5'd9;
    accept();
    n_checks++; if (bus.o_rf_addr !== 5'd9 || bus.o_rf_data !== 32'hABCD_0000)
      $display("FAIL lui: addr %0d data %h want 9 abcd0000", bus.o_rf_addr, bus.o_rf_data); else n_pass++;
    step();

    clear_fields();
    bus.i_reg_write = 1'b1; bus.i_alu = 32'h77; bus.i_register_dst = 5'd0;
    accept();
    n_checks++; if (bus.o_count !== 3'd0 || bus.o_empty !== 1'b1 || bus.o_rf_we !== 1'b0)
      $display("FAIL dst_zero: count %0d empty %b we %b want 0 1 0", bus.o_count, bus.o_empty, bus.o_rf_we); else n_pass++;

    bus.i_reg_write = 1'b0; bus.i_register_dst = 5'd5;
    accept();
    n_checks++; if (bus.o_count !== 3'd0 || bus.o_empty !== 1'b1)
      $display("FAIL no_regwrite: count %0d empty %b want 0 1", bus.o_count, bus.o_empty); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [4:0]  got_addr [8];
    logic [31:0] got_data [8];
    int          n;
    logic        took;
    clear_fields();
    bus.i_rf_ready  = 1'b0;
    bus.i_reg_write = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.i_register_dst = 5'(i);
      bus.i_alu          = 32'h100 + 32'(i);
      accept();
    end
    n_checks++; if (bus.o_full !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_count !== 3'd4)
      $display("FAIL bp_full: full %b ready %b count %0d want 1 0 4", bus.o_full, bus.o_ready, bus.o_count); else n_pass++;

    bus.i_register_dst = 5'd5;
    bus.i_alu          = 32'h105;
    bus.i_valid        = 1'b1;
    step(); step();
    n_checks++; if (bus.o_count !== 3'd4 || bus.o_rf_we !== 1'b0 || bus.o_rf_addr !== 5'd1)
      $display("FAIL bp_hold: count %0d we %b head %0d want 4 0 1", bus.o_count, bus.o_rf_we, bus.o_rf_addr); else n_pass++;

    bus.i_rf_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      #2;
      if (bus.o_rf_we === 1'b1 && n < 8) begin
        got_addr[n] = bus.o_rf_addr;
        got_data[n] = bus.o_rf_data;
        n++;
      end
      took = bus.i_valid & bus.o_ready;
      step();
      if (took) bus.i_valid = 1'b0;
    end
    n_checks++; if (n != 5) $display("FAIL bp_write_count: got %0d want 5", n); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= n || got_addr[i] !== 5'(i + 1) || got_data[i] !== 32'h101 + 32'(i))
        $display("FAIL bp_order[%0d]: addr %0d data %h want %0d %h", i, got_addr[i], got_data[i], i + 1, 32'h101 + 32'(i));
      else n_pass++;
    end
    n_checks++; if (bus.o_empty !== 1'b1 || bus.o_count !== 3'd0)
      $display("FAIL bp_end: empty %b count %0d want 1 0", bus.o_empty, bus.o_count); else n_pass++;
  endtask

  task automatic test_lookup();
    clear_fields();
    bus.i_rf_ready  = 1'b0;
    bus.i_reg_write = 1'b1;
    bus.i_register_dst = 5'd5; bus.i_alu = 32'd1; accept();
    bus.i_register_dst = 5'd5; bus.i_alu = 32'd2; accept();
    bus.i_register_dst = 5'd7; bus.i_alu = 32'd3; accept();
    bus.i_lookup_addr = 5'd5; #1;
    n_checks++; if (bus.o_lookup_hit !== 1'b1 || bus.o_lookup_data !== 32'd2)
      $display("FAIL lookup_r5: hit %b data %h want 1 2", bus.o_lookup_hit, bus.o_lookup_data); else n_pass++;
    bus.i_lookup_addr = 5'd7; #1;
    n_checks++; if (bus.o_lookup_hit !== 1'b1 || bus.o_lookup_data !== 32'd3)
      $display("FAIL lookup_r7: hit %b data %h want 1 3", bus.o_lookup_hit, bus.o_lookup_data); else n_pass++;
    bus.i_lookup_addr = 5'd0; #1;
    n_checks++; if (bus.o_lookup_hit !== 1'b0 || bus.o_lookup_data !== 32'd0)
      $display("FAIL lookup_r0: hit %b data %h want 0 0", bus.o_lookup_hit, bus.o_lookup_data); else n_pass++;
    bus.i_lookup_addr = 5'd9; #1;
    n_checks++; if (bus.o_lookup_hit !== 1'b0 || bus.o_lookup_data !== 32'd0)
      $display("FAIL lookup_miss: hit %b data %h want 0 0", bus.o_lookup_hit, bus.o_lookup_data); else n_pass++;
    bus.i_rf_ready = 1'b1;
    step(); step(); step();
    bus.i_lookup_addr = 5'd5; #1;
    n_checks++; if (bus.o_empty !== 1'b1 || bus.o_lookup_hit !== 1'b0)
      $display("FAIL lookup_drained: empty %b hit %b want 1 0", bus.o_empty, bus.o_lookup_hit); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int stray;
    clear_fields();
    bus.i_rf_ready  = 1'b0;
    bus.i_reg_write = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.i_register_dst = 5'(10 + i);
      bus.i_alu          = 32'(i);
      accept();
    end
    n_checks++; if (bus.o_count !== 3'd3) $display("FAIL mid_count: got %0d want 3", bus.o_count); else n_pass++;
    bus.i_rf_ready = 1'b1;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.o_empty !== 1'b1 || bus.o_count !== 3'd0 || bus.o_rf_we !== 1'b0 || bus.o_ready !== 1'b0)
      $display("FAIL mid_async: empty %b count %0d we %b ready %b want 1 0 0 0", bus.o_empty, bus.o_count, bus.o_rf_we, bus.o_ready); else n_pass++;
    step(); step();
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      #2;
      if (bus.o_rf_we !== 1'b0) stray++;
      step();
    end
    n_checks++; if (stray != 0) $display("FAIL mid_no_write: got %0d strobes want 0", stray); else n_pass++;
    n_checks++; if (bus.o_ready !== 1'b1 || bus.o_empty !== 1'b1)
      $display("FAIL mid_after: ready %b empty %b want 1 1", bus.o_ready, bus.o_empty); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    clear_fields();
    bus.i_rf_ready    = 1'b0;
    bus.i_lookup_addr = 5'd0;
    #1;
    test_reset();
    test_alu_write();
    test_load_filter();
    test_jal_lui();
    test_backpressure();
    test_lookup();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
